// File: rtl/mau_sequencer.sv
// Host-side MAU sequencer: one op in flight; accept->res_valid 13 cycles (mode 1) / 17 (mode 0), or TIMEOUT abort.
// Backpressure: op_ready only in IDLE with MAU idle; result held in RESP until res_ready.
module mau_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_mode,
    input  logic [63:0] op_x,
    input  logic [63:0] op_c,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_0,
    output logic [15:0] res_1,
    output logic        res_err,
    output logic        mau_start,
    output logic        mau_mode,
    output logic [15:0] mau_matram,
    output logic        mau_read_output,
    input  logic        mau_busy,
    inout  wire  [15:0] data_bus_supr,
    inout  wire  [15:0] data_bus_infr
);

    typedef enum logic [3:0] {
        IDLE, START, FEED0, FEED1, FEED2, FEED3, WAIT, READ, RESP
    } state_t;

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic [63:0]   x_q;
    logic [63:0]   c_q;
    logic [CW-1:0] cnt_q;
    logic          op_ready_q;
    logic          res_valid_q;
    logic          res_err_q;
    logic [15:0]   res_0_q;
    logic [15:0]   res_1_q;
    logic          mau_start_q;
    logic          mau_mode_q;
    logic [15:0]   matram_q;
    logic          mau_rd_q;

    // Bus enables decode straight from state so they can never overlap READ.
    logic        drv_en;
    logic [15:0] supr_dat;
    logic [15:0] infr_dat;

    always_comb begin
        drv_en   = (state_q == FEED0) || (state_q == FEED2);
        supr_dat = (state_q == FEED2) ? x_q[47:32] : x_q[15:0];
        infr_dat = (state_q == FEED2) ? x_q[63:48] : x_q[31:16];
    end

    assign data_bus_supr = drv_en ? supr_dat : 16'hzzzz;
    assign data_bus_infr = drv_en ? infr_dat : 16'hzzzz;

    assign op_ready        = op_ready_q;
    assign res_valid       = res_valid_q;
    assign res_err         = res_err_q;
    assign res_0           = res_0_q;
    assign res_1           = res_1_q;
    assign mau_start       = mau_start_q;
    assign mau_mode        = mau_mode_q;
    assign mau_matram      = matram_q;
    assign mau_read_output = mau_rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_0_q     <= '0;
            res_1_q     <= '0;
            mau_start_q <= 1'b0;
            mau_mode_q  <= 1'b0;
            matram_q    <= '0;
            mau_rd_q    <= 1'b0;
        end else begin
            mau_start_q <= 1'b0;
            mau_rd_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Tracks busy so a sequencer reset mid-op waits for the MAU to finish.
                    op_ready_q <= !mau_busy;
                    if (op_valid && op_ready_q) begin
                        x_q         <= op_x;
                        c_q         <= op_c;
                        mau_mode_q  <= op_mode;
                        mau_start_q <= 1'b1;
                        op_ready_q  <= 1'b0;
                        state_q     <= START;
                    end
                end
                START: begin
                    matram_q <= c_q[15:0];
                    state_q  <= FEED0;
                end
                FEED0: begin
                    matram_q <= c_q[31:16];
                    state_q  <= FEED1;
                end
                FEED1: begin
                    matram_q <= c_q[47:32];
                    state_q  <= FEED2;
                end
                FEED2: begin
                    matram_q <= c_q[63:48];
                    state_q  <= FEED3;
                end
                FEED3: begin
                    matram_q <= '0;
                    cnt_q    <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (!mau_busy) begin
                        mau_rd_q <= 1'b1;
                        state_q  <= READ;
                    end else if (cnt_q == CNT_LAST) begin
                        res_0_q     <= '0;
                        res_1_q     <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                READ: begin
                    // infr is left floating by the MAU in 4-term mode.
                    res_0_q     <= data_bus_supr;
                    res_1_q     <= mau_mode_q ? data_bus_infr : 16'h0000;
                    res_err_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        op_ready_q  <= !mau_busy;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mau_sequencer.sv
// Directed bench for mau_sequencer with a behavioural FP16 MAU model on the shared buses.
module tb_mau_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        op_mode = 1'b0;
    logic [63:0] op_x = '0;
    logic [63:0] op_c = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_0;
    logic [15:0] res_1;
    logic        res_err;
    logic        mau_start;
    logic        mau_mode;
    logic [15:0] mau_matram;
    logic        mau_read_output;
    logic        mau_busy = 1'b0;
    wire  [15:0] data_bus_supr;
    wire  [15:0] data_bus_infr;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mau_sequencer #(.TIMEOUT(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode),
        .op_x(op_x), .op_c(op_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_0(res_0), .res_1(res_1), .res_err(res_err),
        .mau_start(mau_start), .mau_mode(mau_mode), .mau_matram(mau_matram),
        .mau_read_output(mau_read_output), .mau_busy(mau_busy),
        .data_bus_supr(data_bus_supr), .data_bus_infr(data_bus_infr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_z(input string nm, input bit ok);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: bus driven, required released (t=%0t)", nm, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real r;
        int  e;
        real m;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0]));
        if (e == 0) r = m * pow2(-24);
        else r = (1.0 + m / 1024.0) * pow2(e - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2f(input real v);
        real  a;
        int   e;
        int   m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, 5'(e + 15), 10'(m)};
    endfunction

    // Behavioural MAU: captures operands on the feed cycles, computes with reals,
    // holds busy for mdl_lat cycles after the start pulse (0 = forever).
    logic        mdl_active = 1'b0;
    int          mdl_start  = 0;
    int          mdl_lat    = 11;
    logic        mdl_abort  = 1'b0;
    logic        mdl_drop   = 1'b0;
    logic        mdl_mode   = 1'b0;
    logic [15:0] mdl_r0     = '0;
    logic [15:0] mdl_r1     = '0;
    logic [63:0] cap_x      = '0;
    logic [63:0] cap_c      = '0;

    assign data_bus_supr = mau_read_output ? mdl_r0 : 16'hzzzz;
    assign data_bus_infr = (mau_read_output && mdl_mode) ? mdl_r1 : 16'hzzzz;

    always @(negedge clk) begin : mau_model
        int  k;
        real p0, p1, p2, p3;
        if (mdl_drop) begin
            mau_busy   = 1'b0;
            mdl_active = 1'b0;
        end else if (!mdl_active && mau_start === 1'b1 && reset_n) begin
            mdl_active = 1'b1;
            mdl_start  = cyc;
            mdl_mode   = mau_mode;
            mau_busy   = 1'b1;
        end else if (mdl_active) begin
            k = cyc - mdl_start;
            if (!mdl_abort) begin
                case (k)
                    1: begin
                        chk("start_one_cycle", mau_start, 1'b0);
                        cap_x[31:0]  = {data_bus_infr, data_bus_supr};
                        cap_c[15:0]  = mau_matram;
                    end
                    2: begin
                        chk_z("supr_released_feed1", data_bus_supr === 16'hzzzz);
                        chk_z("infr_released_feed1", data_bus_infr === 16'hzzzz);
                        cap_c[31:16] = mau_matram;
                    end
                    3: begin
                        cap_x[63:32] = {data_bus_infr, data_bus_supr};
                        cap_c[47:32] = mau_matram;
                    end
                    4: begin
                        chk_z("supr_released_feed3", data_bus_supr === 16'hzzzz);
                        chk_z("infr_released_feed3", data_bus_infr === 16'hzzzz);
                        chk("mode_stable", mau_mode, mdl_mode);
                        cap_c[63:48] = mau_matram;
                        p0 = f2r(cap_x[15:0])  * f2r(cap_c[15:0]);
                        p1 = f2r(cap_x[31:16]) * f2r(cap_c[31:16]);
                        p2 = f2r(cap_x[47:32]) * f2r(cap_c[47:32]);
                        p3 = f2r(cap_x[63:48]) * f2r(cap_c[63:48]);
                        if (mdl_mode) begin
                            mdl_r0 = r2f(p0 + p1);
                            mdl_r1 = r2f(p2 + p3);
                        end else begin
                            mdl_r0 = r2f(p0 + p1 + p2 + p3);
                            mdl_r1 = 16'h0000;
                        end
                    end
                    default: ;
                endcase
            end
            if (mdl_lat != 0 && k == mdl_lat) begin
                mau_busy   = 1'b0;
                mdl_active = 1'b0;
            end
        end
        // Contention: any second driver during READ corrupts the model's value.
        if (mau_read_output === 1'b1) begin
            chk("supr_read_clean", data_bus_supr, mdl_r0);
            if (mdl_mode) chk("infr_read_clean", data_bus_infr, mdl_r1);
            else chk_z("infr_undriven_mode0", data_bus_infr === 16'hzzzz);
        end
    end

    typedef struct {
        logic        mode;
        logic [63:0] x;
        logic [63:0] c;
        int          lat;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eerr;
        int          elat;
        int          hold;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        int acc;
        int n;
        mdl_lat  = v.lat;
        op_mode  = v.mode;
        op_x     = v.x;
        op_c     = v.c;
        op_valid = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("op_ready_before_accept", op_ready, 1'b1);
        tick();
        acc = cyc;
        op_valid = 1'b0;
        chk("op_ready_after_accept", op_ready, 1'b0);
        n = 0;
        while (res_valid !== 1'b1 && n < 80) begin tick(); n++; end
        chk("latency", 64'(cyc - acc), 64'(v.elat));
        chk("start_cycle", 64'(mdl_start - acc), 64'd0);
        chk("res_0", res_0, v.e0);
        chk("res_1", res_1, v.e1);
        chk("res_err", res_err, v.eerr);
        chk("fed_x", cap_x, v.x);
        chk("fed_c", cap_c, v.c);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_0", res_0, v.e0);
            chk("hold_res_1", res_1, v.e1);
            chk("hold_op_ready", op_ready, 1'b0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_cleared", res_valid, 1'b0);
        chk("res_err_cleared", res_err, 1'b0);
        chk("op_ready_after_resp", op_ready, (v.lat != 0) ? 1'b1 : 1'b0);
    endtask

    initial begin : main
        int n;
        vecs[0] = '{1'b1, 64'h4000_3C00_4000_3C00, 64'h3C00_3C00_3C00_3C00, 11,
                    16'h4200, 16'h4200, 1'b0, 13, 0};
        vecs[1] = '{1'b0, 64'h3C00_3C00_3C00_3C00, 64'h4000_4000_4000_4000, 15,
                    16'h4800, 16'h0000, 1'b0, 17, 5};
        vecs[2] = '{1'b1, 64'hC000_4000_3800_4400, 64'h3C00_3C00_4000_4000, 11,
                    16'h4880, 16'h0000, 1'b0, 13, 1};
        vecs[3] = '{1'b1, 64'h4000_3C00_4000_3C00, 64'h3C00_3C00_3C00_3C00, 0,
                    16'h0000, 16'h0000, 1'b1, 37, 2};

        #2 reset_n = 1'b0;
        #1;
        chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_res", {res_1, res_0}, 32'h0);
        chk("rst_mau_start", mau_start, 1'b0);
        chk("rst_mau_mode", mau_mode, 1'b0);
        chk("rst_matram", mau_matram, 16'h0);
        chk("rst_read_output", mau_read_output, 1'b0);
        chk_z("rst_supr_z", data_bus_supr === 16'hzzzz);
        chk_z("rst_infr_z", data_bus_infr === 16'hzzzz);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("op_ready_after_reset", op_ready, 1'b1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // MAU still busy after the timeout: requests must be refused.
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_blocks_start", mau_start, 1'b0);
            chk("busy_blocks_ready", op_ready, 1'b0);
        end
        op_valid = 1'b0;
        mdl_drop = 1'b1;
        tick();
        mdl_drop = 1'b0;
        tick();
        chk("ready_after_busy_drop", op_ready, 1'b1);

        // Reset during FEED2, MAU keeps running to completion.
        mdl_lat  = 11;
        op_mode  = 1'b1;
        op_x     = vecs[0].x;
        op_c     = vecs[0].c;
        op_valid = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        op_valid = 1'b0;
        n = 0;
        while (!(mdl_active && (cyc - mdl_start) == 3) && n < 20) begin tick(); n++; end
        chk("reached_feed2", 64'(cyc - mdl_start), 64'd3);
        mdl_abort = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk_z("midrst_supr_z", data_bus_supr === 16'hzzzz);
        chk_z("midrst_infr_z", data_bus_infr === 16'hzzzz);
        chk("midrst_start", mau_start, 1'b0);
        chk("midrst_op_ready", op_ready, 1'b0);
        chk("midrst_matram", mau_matram, 16'h0);
        tick();
        reset_n = 1'b1;
        for (int k = 5; k <= 11; k++) begin
            tick();
            chk("midrst_ready_while_busy", op_ready, 1'b0);
        end
        tick();
        chk("midrst_ready_after_busy", op_ready, 1'b1);
        chk("midrst_no_result", res_valid, 1'b0);
        mdl_abort = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        n_err++;
        $display("FAIL watchdog: got no completion, required finish before 100000 time units");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mau_sequencer.md
Name: mau_sequencer

Overview:
- Initiator-side controller for the Matrix Acceleration Unit (MAU).
- Accepts one operand packet from the host through a valid/ready handshake, then drives the MAU's start, mode, matRAM and shared tri-state operand buses with exact cycle alignment.
- Waits for MAU busy to drop, reads the FP16 result(s) back over the same buses, and returns them to the host through a valid/ready result port.
- Sits between the GPU command path and the MAU; one operation in flight at a time.

Parameters:
TIMEOUT, 32, maximum cycles spent in WAIT before aborting with res_err.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
op_valid  input  1  host request valid
op_ready  output  1  sequencer can accept a request
op_mode  input  1  0 = 4-term dot product (n*3/n*4); 1 = two 2-term dot products (n*2)
op_x  input  64  vector words x0..x3 (x0 = [15:0]), FP16
op_c  input  64  matrix words c0..c3 (c0 = [15:0]), FP16
res_valid  output  1  result valid
res_ready  input  1  host accepts result
res_0  output  16  result read from data_bus_supr
res_1  output  16  result read from data_bus_infr; 0 when mode = 0
res_err  output  1  result aborted by timeout
mau_start  output  1  MAU start
mau_mode  output  1  MAU mode; held stable from START through READ
mau_matram  output  16  MAU matRAM word
mau_read_output  output  1  MAU read_output
mau_busy  input  1  MAU busy
data_bus_supr  inout  16  shared bus, tri-state
data_bus_infr  inout  16  shared bus, tri-state

Behaviour:
- Reset values (async, reset_n = 0):
  - State IDLE.
  - op_ready = 0, res_valid = 0, res_err = 0, res_0/res_1 = 0.
  - mau_start = 0, mau_mode = 0, mau_matram = 0, mau_read_output = 0.
  - Both buses released to 'z.
- Registers: all outputs registered except bus enables, which decode from state.
- States: IDLE, START, FEED0, FEED1, FEED2, FEED3, WAIT, READ, RESP.
- IDLE:
  - op_ready = !mau_busy. This covers a sequencer reset while the MAU is still mid-operation.
  - On op_valid && op_ready: latch op_x, op_c, op_mode into internal registers, load mau_mode, go to START.
- START (cycle T): mau_start = 1 for exactly this cycle; go to FEED0.
- FEED0 (T+1): drive supr = x0, infr = x1, matram = c0 (captured by MAU at the end of T+1).
- FEED1 (T+2): matram = c1; buses 'z.
- FEED2 (T+3): supr = x2, infr = x3, matram = c2.
- FEED3 (T+4): matram = c3; buses 'z. Go to WAIT.
- Bus driving rule: the sequencer drives the buses only in FEED0 and FEED2; otherwise 'z. It must never drive while mau_read_output = 1.
- WAIT (from T+5):
  - Cycle counter starts at 0.
  - mau_busy = 0 → READ.
  - Counter reaching TIMEOUT-1 with busy still high → RESP with res_err = 1, res_0 = res_1 = 0.
- Nominal busy-low cycle: T+11 for mode 1, T+15 for mode 0.
- READ:
  - mau_read_output = 1 for one cycle; buses 'z from the sequencer side.
  - Sample supr → res_0 at the end of the cycle.
  - Sample infr → res_1 only when mode = 1, else res_1 = 0. The infr bus is undriven in mode 0.
  - Go to RESP.
- RESP:
  - res_valid = 1; res_0, res_1 and res_err held stable until res_ready.
  - On res_valid && res_ready: clear res_valid and res_err, go to IDLE.
  - res_ready asserted early has no effect.
- End-to-end latency (accept edge → res_valid): 13 cycles for mode 1, 17 cycles for mode 0, with no timeout.
- Back-to-back: the next op_ready is asserted in the cycle after the RESP handshake. op_valid is ignored outside IDLE.
- mau_busy high while in IDLE blocks acceptance; no start pulse is issued.
- reset_n asserted mid-operation: immediate return to IDLE, buses released, any pending result dropped.
- Unexpected mau_busy = 0 during FEED states: ignored; the sequence completes.

Test Plan:
- Mode 1, x = {0x3C00, 0x4000, 0x3C00, 0x4000}, c = all 0x3C00 → start pulse at T; buses show x0/x1 at T+1 and x2/x3 at T+3; matram c0..c3 at T+1..T+4; res_valid at accept+13 with res_0 = 0x4200 (3.0), res_1 = 0x4200, res_err = 0.
- Mode 0, x = all 0x3C00, c = all 0x4000 → res_valid at accept+17, res_0 = 0x4800 (8.0), res_1 = 0x0000.
- Hold res_ready low 5 cycles after res_valid → res_0, res_1 and res_valid stable; op_ready = 0 throughout; completes one cycle after res_ready rises.
- Behavioural MAU model holds busy high forever, TIMEOUT = 32 → res_valid with res_err = 1, res_0 = res_1 = 0, at accept+5+32.
- reset_n low during FEED2 → next cycle shows buses 'z, mau_start = 0, op_ready = 0 while mau_busy = 1; op_ready rises when the model drops busy.
- Bus contention monitor across all tests: sequencer and MAU never both drive a non-'z value on either bus in the same cycle.
